// File: rtl/main_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// PkgMainMemArbiter
// Shared types for the two-port main memory arbiter: FSM state encoding,
// requester port indices, access type encoding (same values as the CPU's
// DiatRead/DiatWrite) and the per-requester request/response bundles.
// ---------------------------------------------------------------------------
package PkgMainMemArbiter;

   // Access type encoding carried on type_* and mem_type.
   typedef enum logic {
      DiatRead  = 1'b0,
      DiatWrite = 1'b1
   } access_type_t;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   // Requester indices: instruction fetch and data port.
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DT = 1'b1;

   // Everything a requester presents to the arbiter.
   typedef struct packed {
      logic         req;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      access_type_t access_type;
   } PortIn_ReqPort;

   // Everything the arbiter returns to a requester.
   typedef struct packed {
      logic        done;
      logic [31:0] rdata;
   } PortOut_ReqPort;

endpackage

// File: rtl/main_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// main_mem_rr_pick
// Combinational round-robin pick between the fetch and data requesters.
// Ports:
//   req_if, req_dt  in   pending requests from fetch (0) and data (1)
//   last_grant      in   port served by the previous transaction
//   grant_valid     out  at least one request is pending
//   grant_idx       out  port to serve next
// ---------------------------------------------------------------------------
module main_mem_rr_pick
   import PkgMainMemArbiter::*;
(
   input  logic req_if,
   input  logic req_dt,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_idx
);

   // On a tie the port that was not served last wins; a lone request
   // always wins regardless of history.
   always_comb begin
      grant_valid = req_if | req_dt;
      if (req_if && req_dt) begin
         grant_idx = ~last_grant;
      end else if (req_dt) begin
         grant_idx = PORT_DT;
      end else begin
         grant_idx = PORT_IF;
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// ---------------------------------------------------------------------------
// main_mem_arbiter
// Shares a single MainMem between the instruction-fetch and data ports.
// One transaction at a time: IDLE -> ISSUE (mem_req for one cycle) ->
// WAIT (until MainMem drops wait) -> DONE (one-cycle done pulse).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_*/addr_*/wdata_*/type_*   requester inputs (if = fetch, dt = data)
//   done_*/rdata_*                requester completion pulse and read data
//   mem_req/mem_addr/mem_wdata/mem_type   downstream MainMem request
//   mem_wait/mem_rdata            MainMem busy flag and read data
//   timeout_err                   sticky flag: WAIT lasted TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module main_mem_arbiter
   import PkgMainMemArbiter::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_if,
   input  logic        req_dt,
   input  logic [31:0] addr_if,
   input  logic [31:0] addr_dt,
   input  logic [31:0] wdata_if,
   input  logic [31:0] wdata_dt,
   input  logic        type_if,
   input  logic        type_dt,
   output logic        done_if,
   output logic        done_dt,
   output logic [31:0] rdata_if,
   output logic [31:0] rdata_dt,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_type,
   input  logic        mem_wait,
   input  logic [31:0] mem_rdata,
   output logic        timeout_err
);

   localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT_CYCLES - 1);

   state_t         state;
   logic           last_grant;
   logic           cur_port;
   logic [31:0]    wait_cnt;
   logic           grant_valid;
   logic           grant_idx;
   PortIn_ReqPort  in_if;
   PortIn_ReqPort  in_dt;
   PortIn_ReqPort  sel;
   PortOut_ReqPort out_if;
   PortOut_ReqPort out_dt;

   assign in_if = '{req: req_if, addr: addr_if, wdata: wdata_if,
                    access_type: access_type_t'(type_if)};
   assign in_dt = '{req: req_dt, addr: addr_dt, wdata: wdata_dt,
                    access_type: access_type_t'(type_dt)};
   assign sel   = grant_idx ? in_dt : in_if;

   assign done_if  = out_if.done;
   assign rdata_if = out_if.rdata;
   assign done_dt  = out_dt.done;
   assign rdata_dt = out_dt.rdata;

   main_mem_rr_pick u_pick (
      .req_if      (req_if),
      .req_dt      (req_dt),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Single-process FSM with registered outputs. MainMem has no reset of
   // its own, so a grant in IDLE also waits for mem_wait to be low; this
   // keeps us from issuing into an access abandoned by a mid-flight reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= PORT_DT;
         cur_port    <= PORT_IF;
         mem_req     <= 1'b0;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         mem_type    <= DiatRead;
         out_if      <= '0;
         out_dt      <= '0;
         wait_cnt    <= 32'd0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid && sel.req && !mem_wait) begin
                  cur_port  <= grant_idx;
                  mem_addr  <= sel.addr;
                  mem_wdata <= sel.wdata;
                  mem_type  <= sel.access_type;
                  mem_req   <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_req  <= 1'b0;
               wait_cnt <= 32'd0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
               if (!mem_wait) begin
                  if (cur_port == PORT_DT) begin
                     out_dt <= '{done: 1'b1, rdata: mem_rdata};
                  end else begin
                     out_if <= '{done: 1'b1, rdata: mem_rdata};
                  end
                  state <= DONE;
               end else if (wait_cnt >= WAIT_LIMIT) begin
                  // Flag only; the access keeps waiting for MainMem.
                  timeout_err <= 1'b1;
               end
            end
            DONE: begin
               out_if.done <= 1'b0;
               out_dt.done <= 1'b0;
               last_grant  <= cur_port;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_main_mem_arbiter
// Directed bench for main_mem_arbiter with a behavioural 4-cycle MainMem
// model and a scoreboard of expected completions.
// ---------------------------------------------------------------------------
module tb_main_mem_arbiter;
   import PkgMainMemArbiter::*;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        req_if, req_dt;
   logic [31:0] addr_if, addr_dt, wdata_if, wdata_dt;
   logic        type_if, type_dt;
   logic        done_if, done_dt;
   logic [31:0] rdata_if, rdata_dt;
   logic        mem_req;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_type;
   logic        mem_wait = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        timeout_err;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int done_count = 0;
   int n_pushed = 0;
   int mem_req_cycles = 0;

   typedef struct {
      logic        port;
      logic        check_data;
      logic [31:0] data;
      int          exp_cyc;
   } sb_entry_t;

   sb_entry_t sb[$];

   main_mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_if      (req_if),
      .req_dt      (req_dt),
      .addr_if     (addr_if),
      .addr_dt     (addr_dt),
      .wdata_if    (wdata_if),
      .wdata_dt    (wdata_dt),
      .type_if     (type_if),
      .type_dt     (type_dt),
      .done_if     (done_if),
      .done_dt     (done_dt),
      .rdata_if    (rdata_if),
      .rdata_dt    (rdata_dt),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_type    (mem_type),
      .mem_wait    (mem_wait),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // MainMem model: words not yet written read back a fixed pattern.
   logic [31:0] mem_words [256];
   bit          written [256];
   int          busy_cnt = 0;
   logic        stall = 1'b0;
   logic [7:0]  p_idx = 8'd0;
   logic [31:0] p_wdata = 32'd0;
   logic        p_write = 1'b0;

   function automatic logic [31:0] init_word(input logic [7:0] idx);
      if (idx == 8'd4) return 32'hDEADBEEF;
      return 32'hA5A5_0000 | {24'd0, idx};
   endfunction

   // Wait is high for four cycles after the request cycle; stall holds
   // it high indefinitely to provoke the timeout.
   always @(posedge clk) begin
      if (mem_req) begin
         mem_wait <= 1'b1;
         busy_cnt <= 3;
         p_idx    <= mem_addr[9:2];
         p_wdata  <= mem_wdata;
         p_write  <= mem_type;
      end else if (mem_wait) begin
         if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
         end else if (!stall) begin
            mem_wait <= 1'b0;
            if (p_write) begin
               mem_words[p_idx] <= p_wdata;
               written[p_idx]   <= 1'b1;
               mem_rdata        <= p_wdata;
            end else begin
               mem_rdata <= written[p_idx] ? mem_words[p_idx] : init_word(p_idx);
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) mem_req_cycles++;
         if (done_if || done_dt) begin
            done_count++;
            checkOutput("both_done", {31'd0, done_if & done_dt}, 32'd0);
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", {31'd0, done_if | done_dt}, 32'd0);
            end else begin
               automatic sb_entry_t e = sb.pop_front();
               checkOutput("done_port", {31'd0, done_dt}, {31'd0, e.port});
               if (e.check_data)
                  checkOutput("rdata", done_dt ? rdata_dt : rdata_if, e.data);
               if (e.exp_cyc >= 0)
                  checkOutput("done_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
         end
      end
   end

   task automatic pushExpected(input logic port, input logic check_data,
                               input logic [31:0] data, input int exp_cyc);
      sb.push_back('{port, check_data, data, exp_cyc});
      n_pushed++;
   endtask

   task automatic applyStimulus(input logic port, input logic is_write,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port == PORT_DT) begin
         req_dt = 1'b1; addr_dt = addr; wdata_dt = wdata; type_dt = is_write;
      end else begin
         req_if = 1'b1; addr_if = addr; wdata_if = wdata; type_if = is_write;
      end
   endtask

   task automatic waitDones(input string tag, input int budget);
      int n = 0;
      while (done_count < n_pushed && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput(tag, 32'(done_count), 32'(n_pushed));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, "_done"}, {30'd0, done_if, done_dt}, 32'd0);
      checkOutput({tag, "_rdata_if"}, rdata_if, 32'd0);
      checkOutput({tag, "_rdata_dt"}, rdata_dt, 32'd0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_mem_type"}, {31'd0, mem_type}, 32'd0);
      checkOutput({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
   endtask

   initial begin
      int base;
      rst = 1'b1;
      req_if = 1'b0; req_dt = 1'b0;
      addr_if = '0; addr_dt = '0; wdata_if = '0; wdata_dt = '0;
      type_if = 1'b0; type_dt = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      // Tie after reset: fetch first, then alternate while both held.
      @(negedge clk);
      applyStimulus(PORT_IF, 1'b0, 32'h40, 32'd0);
      applyStimulus(PORT_DT, 1'b0, 32'h44, 32'd0);
      pushExpected(PORT_IF, 1'b1, 32'hA5A5_0010, -1);
      pushExpected(PORT_DT, 1'b1, 32'hA5A5_0011, -1);
      pushExpected(PORT_IF, 1'b1, 32'hA5A5_0010, -1);
      pushExpected(PORT_DT, 1'b1, 32'hA5A5_0011, -1);
      waitDones("tie_dones", 60);
      req_if = 1'b0; req_dt = 1'b0;
      repeat (2) @(negedge clk);

      // Single fetch read: done exactly 7 cycles after the request.
      base = mem_req_cycles;
      applyStimulus(PORT_IF, 1'b0, 32'h10, 32'd0);
      pushExpected(PORT_IF, 1'b1, 32'hDEADBEEF, cyc + 7);
      waitDones("fetch_dones", 20);
      req_if = 1'b0;
      checkOutput("fetch_mem_addr", mem_addr, 32'h10);
      checkOutput("fetch_mem_req_width", 32'(mem_req_cycles - base), 32'd1);
      checkOutput("fetch_rdata_dt_kept", rdata_dt, 32'hA5A5_0011);
      repeat (2) @(negedge clk);

      // Data write then fetch read of the same word.
      applyStimulus(PORT_DT, 1'b1, 32'h20, 32'h12345678);
      pushExpected(PORT_DT, 1'b0, 32'd0, -1);
      waitDones("write_dones", 20);
      req_dt = 1'b0;
      checkOutput("write_mem_type", {31'd0, mem_type}, 32'd1);
      checkOutput("write_mem_wdata", mem_wdata, 32'h12345678);
      repeat (2) @(negedge clk);
      applyStimulus(PORT_IF, 1'b0, 32'h20, 32'd0);
      pushExpected(PORT_IF, 1'b1, 32'h12345678, -1);
      waitDones("readback_dones", 20);
      req_if = 1'b0;
      repeat (2) @(negedge clk);

      // Upper address bits reach MainMem untouched.
      applyStimulus(PORT_IF, 1'b0, 32'hABCD_0014, 32'd0);
      pushExpected(PORT_IF, 1'b1, 32'hA5A5_0005, -1);
      waitDones("upper_addr_dones", 20);
      req_if = 1'b0;
      checkOutput("upper_mem_addr", mem_addr, 32'hABCD_0014);
      repeat (2) @(negedge clk);

      // Data port held high for three transactions, 8 cycles apart.
      applyStimulus(PORT_DT, 1'b0, 32'h30, 32'd0);
      pushExpected(PORT_DT, 1'b1, 32'hA5A5_000C, cyc + 7);
      pushExpected(PORT_DT, 1'b1, 32'hA5A5_000C, cyc + 15);
      pushExpected(PORT_DT, 1'b1, 32'hA5A5_000C, cyc + 23);
      waitDones("b2b_dones", 40);
      req_dt = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in WAIT: no done, reset outputs, no grant while mem busy.
      applyStimulus(PORT_IF, 1'b0, 32'h10, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetOutputs("midrst");
      checkOutput("midrst_mem_busy", {31'd0, mem_wait}, 32'd1);
      rst = 1'b0;
      pushExpected(PORT_IF, 1'b1, 32'hDEADBEEF, -1);
      for (int i = 0; i < 10 && mem_wait; i++) begin
         checkOutput("midrst_no_grant", {31'd0, mem_req}, 32'd0);
         @(negedge clk);
      end
      waitDones("midrst_dones", 20);
      req_if = 1'b0;
      checkOutput("midrst_rdata_dt_kept", rdata_dt, 32'd0);
      repeat (2) @(negedge clk);

      // Timeout: MainMem stalls; flag rises, stays, access still completes.
      stall = 1'b1;
      applyStimulus(PORT_IF, 1'b0, 32'h10, 32'd0);
      pushExpected(PORT_IF, 1'b1, 32'hDEADBEEF, -1);
      repeat (12) @(negedge clk);
      checkOutput("timeout_early", {31'd0, timeout_err}, 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("timeout_set", {31'd0, timeout_err}, 32'd1);
      checkOutput("timeout_no_done", 32'(done_count), 32'(n_pushed - 1));
      stall = 1'b0;
      waitDones("timeout_dones", 20);
      req_if = 1'b0;
      checkOutput("timeout_sticky", {31'd0, timeout_err}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("timeout_cleared", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max WAIT-state cycles before a timeout is flagged.
REQ-002 clk  in  1  system clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_if, req_dt  in  1 each  access request from the instruction-fetch port (0) and the data port (1).
REQ-005 addr_if, addr_dt  in  32 each  byte address, held stable while the matching req is high.
REQ-006 wdata_if, wdata_dt  in  32 each  write data, held stable while req is high.
REQ-007 type_if, type_dt  in  1 each  access type, PkgFrost32Cpu DiatRead/DiatWrite.
REQ-008 done_if, done_dt  out  1 each  one-cycle completion pulse to the requester.
REQ-009 rdata_if, rdata_dt  out  32 each  read data, valid while the matching done is high.
REQ-010 mem_req  out  1  drives MainMem req_mem_access.
REQ-011 mem_addr, mem_wdata  out  32 each  drive MainMem addr and data.
REQ-012 mem_type  out  1  drives MainMem data_inout_access_type.
REQ-013 mem_wait  in  1  MainMem wait_for_mem.
REQ-014 mem_rdata  in  32  MainMem data.
REQ-015 timeout_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: with any req high and mem_wait==0, select the grant, latch addr/wdata/type of the granted port, go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration: round-robin; when both reqs are high, the port not granted last wins; a single req always wins.
REQ-019 ISSUE: mem_req=1 for exactly one cycle, then go to WAIT.
REQ-020 mem_req=0 in every state except ISSUE.
REQ-021 mem_addr/mem_wdata/mem_type hold the latched values from ISSUE through DONE, and keep the last values in IDLE.
REQ-022 WAIT: with mem_wait==0, register mem_rdata into the granted port's rdata and go to DONE; otherwise stay in WAIT.
REQ-023 DONE: assert the granted port's done for one cycle, update last_grant, ignore all reqs, go to IDLE.
REQ-024 Writes follow the same sequence; rdata for a write is don't-care but is still updated.
REQ-025 Keeping req high after done starts a new, independent transaction, subject to arbitration.
REQ-026 With MainMem's 4-cycle access, req high in IDLE at cycle 0 gives done at cycle 7.
REQ-027 A 32-bit WAIT counter counts cycles in WAIT; at TIMEOUT_CYCLES, set timeout_err and keep waiting (no abort).
REQ-028 Only one done is high in any cycle; rdata of the non-granted port is unchanged.
REQ-029 addr[31:16] passes to MainMem unmodified; wrapping modulo 64 KiB is MainMem's job.

Reset
REQ-030 rst: state IDLE, last_grant=1 (data port, so fetch wins the first tie), mem_req=0, done_*=0, rdata_*=0, mem_addr/mem_wdata=0, mem_type=DiatRead, WAIT counter 0, timeout_err=0.
REQ-031 rst mid-transaction abandons the access without any done pulse.
REQ-032 MainMem has no reset, so after rst no grant occurs until mem_wait==0.

Structure
REQ-033 PkgMainMemArbiter holds the state enum, the port index constants (PORT_IF=0, PORT_DT=1), and the PortIn_ReqPort/PortOut_ReqPort structs.
REQ-034 Access types reuse PkgFrost32Cpu; the downstream bundle maps onto PkgMainMem::PortIn_MainMem and PortOut_MainMem.
REQ-035 One combinational sub-module, main_mem_rr_pick, takes (req_if, req_dt, last_grant) and returns (grant_valid, grant_idx).

Verification
REQ-036 Single fetch read: req_if=1, addr_if=0x10, mem holds 0xDEADBEEF at 0x10..0x13 -> done_if at cycle 7, rdata_if=0xDEADBEEF, done_dt never high.
REQ-037 Simultaneous reqs after reset: both high -> fetch served first, data second; with reqs held high, grants alternate if, dt, if, dt.
REQ-038 Data write then fetch read: dt write 0x12345678 to 0x20, then if read of 0x20 -> rdata_if=0x12345678.
REQ-039 Reset during WAIT: assert rst while in WAIT -> no done pulse, all outputs at reset values; the next request waits for mem_wait==0 and then completes correctly.
REQ-040 Timeout: a stub holds mem_wait=1 -> timeout_err rises after TIMEOUT_CYCLES WAIT cycles and stays set; after mem_wait drops, the transaction completes with a done pulse.
REQ-041 Back-to-back single requester: req_dt held high for three transactions -> three done_dt pulses, 8 cycles apart.
